i2s_adc_receiver: RTL
=====================

I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

Interface
REQ-001 Parameter: DATA_W, default 32, number of bits per channel slot (MSB first); legal range 8..32.
REQ-002 Port: clk  input  1  system clock; one clock, all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  receive enable; low forces SYNC state and suppresses outputs.
REQ-005 Port: bclk  input  1  I2S bit clock from external ADC, asynchronous to clk.
REQ-006 Port: lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-007 Port: sdata  input  1  I2S serial data, asynchronous, changes on bclk falling edge.
REQ-008 Port: left_data  output  DATA_W  last complete left word.
REQ-009 Port: right_data  output  DATA_W  last complete right word.
REQ-010 Port: sample_valid  output  1  one-clk pulse when left_data/right_data update as a pair.
REQ-011 Port: frame_err  output  1  one-clk pulse on a malformed channel slot.

Function
REQ-012 bclk, lrclk, sdata SHALL each pass through an identical 2-flop synchronizer so their relative alignment is preserved.
REQ-013 A bclk rising edge SHALL be detected as synced bclk = 1 with previous synced bclk = 0; all receive actions occur only on that clk cycle.
REQ-014 clk frequency SHALL be at least 8x bclk; behaviour below that ratio is undefined.
REQ-015 At every detected bclk rise, synced sdata SHALL be shifted into a DATA_W shift register at the LSB (MSB arrives first).
REQ-016 A slot boundary is a bclk rise where synced lrclk differs from lrclk captured at the previous bclk rise; the bit shifted at that rise is the last (LSB) bit of the ending slot (standard I2S one-bit delay).
REQ-017 bit_cnt SHALL count shifts since the last boundary, saturating at DATA_W+1; reset to 0 at each boundary after evaluation.
REQ-018 States: SYNC, LEFT, RIGHT; reset and en = 0 force SYNC.
REQ-019 SYNC -> LEFT on a boundary where new lrclk = 0; all other boundaries and bits in SYNC are discarded without error.
REQ-020 LEFT -> RIGHT on boundary with new lrclk = 1: if count including this bit = DATA_W, shift register copied to internal left_hold; else frame_err pulses and state -> SYNC.
REQ-021 RIGHT -> LEFT on boundary with new lrclk = 0: if count = DATA_W, left_data <= left_hold, right_data <= completed word, sample_valid pulses; else frame_err pulses and state -> SYNC, outputs unchanged.
REQ-022 Output update and sample_valid SHALL occur on the clk edge 3 cycles after the clk edge that first samples the bclk rise at the pin (2 sync + 1 action).
REQ-023 sample_valid and frame_err SHALL never assert in the same cycle.
REQ-024 Bits beyond DATA_W in a slot (count saturated) SHALL be treated as error at the next boundary; short slots likewise.
REQ-025 en falling mid-slot SHALL discard partial data; left_data/right_data hold last valid values.

Reset
REQ-026 On rst = 1 at a clk edge: state = SYNC, bit_cnt = 0, shift register = 0, left_hold = 0, left_data = 0, right_data = 0, sample_valid = 0, frame_err = 0, synchronizers = 0.
REQ-027 rst asserted mid-slot SHALL abort the frame; first sample_valid after release requires a fresh left-start boundary plus full left and right slots.

Verification
REQ-028 clk = 32x bclk, DATA_W = 32, frames L = 0xA5A5_0001, R = 0x1234_5678 -> first frame after lock yields sample_valid once with those exact values; subsequent frames one pulse per frame.
REQ-029 Stream starting mid-right-slot -> no sample_valid, no frame_err until first complete L/R pair after left-start boundary.
REQ-030 Left slot of 31 bits -> frame_err single pulse at right boundary, state SYNC, outputs keep previous pair; recovery on next full frame.
REQ-031 Right slot of 33 bits -> frame_err at next left boundary, no sample_valid for that frame.
REQ-032 rst pulsed during right slot, and separately en dropped during left slot -> outputs per REQ-026 / held values, correct data on second subsequent frame.
REQ-033 Measure latency: sample_valid rises exactly 3 clk edges after the sampling edge of the final bclk rise of the right slot.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_adc_receiver
//
// Receives a standard I2S stereo stream from an external ADC and presents
// the most recent complete left/right pair in the clk domain. bclk, lrclk
// and sdata are asynchronous. They are brought in through identical 2-flop
// synchronizers, so their relative alignment is preserved. All receive
// actions happen on the clk cycle that follows a detected bclk rise.
//
// Ports
//   clk           system clock, rising edge; must be at least 8x bclk
//   rst           synchronous, active-high reset
//   en            receive enable; low holds the FSM in SYNC, no pulses
//   bclk          I2S bit clock (async)
//   lrclk         I2S word select (async), 0 = left, 1 = right
//   sdata         I2S serial data (async), changes on bclk falling edge
//   left_data     last complete left word
//   right_data    last complete right word
//   sample_valid  one-clk pulse when left_data/right_data update as a pair
//   frame_err     one-clk pulse on a malformed channel slot
//
// state | meaning
// ------+-----------------------------------------------------------------
// SYNC  | not locked; wait for a boundary that starts a left slot
// LEFT  | receiving the left slot; right boundary validates its length
// RIGHT | receiving the right slot; left boundary publishes the pair
// ---------------------------------------------------------------------------
module i2s_adc_receiver #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic              sdata,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              frame_err
);

   localparam int              CNT_W    = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   state_t state, state_nxt;

   // synchronizers and edge detect
   logic [1:0] bclk_sync;
   logic [1:0] lrclk_sync;
   logic [1:0] sdata_sync;
   logic       bclk_prev;
   logic       rise_q;
   logic       lr_q;
   logic       sd_q;

   // receive datapath
   logic [DATA_W-2:0] shreg;
   logic [DATA_W-1:0] word_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  cnt_incl;
   logic              lr_prev;
   logic [DATA_W-1:0] left_hold;
   logic              boundary;
   logic              cnt_ok;

   // FSM decisions
   logic load_left;
   logic pair_done;
   logic slot_err;

   // The rise event and the data/word-select bits seen with it are
   // registered together. As a result, the action edge is the third clk
   // edge after the pin is first sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_sync  <= '0;
         lrclk_sync <= '0;
         sdata_sync <= '0;
         bclk_prev  <= 1'b0;
         rise_q     <= 1'b0;
         lr_q       <= 1'b0;
         sd_q       <= 1'b0;
      end else begin
         bclk_sync  <= {bclk_sync[0], bclk};
         lrclk_sync <= {lrclk_sync[0], lrclk};
         sdata_sync <= {sdata_sync[0], sdata};
         bclk_prev  <= bclk_sync[1];
         rise_q     <= bclk_sync[1] & ~bclk_prev;
         lr_q       <= lrclk_sync[1];
         sd_q       <= sdata_sync[1];
      end
   end

   // The full word is the DATA_W-1 stored bits plus the bit arriving now.
   // Only DATA_W-1 bits need storage.
   assign word_nxt = {shreg, sd_q};
   assign boundary = rise_q && (lr_q != lr_prev);
   assign cnt_incl = (bit_cnt == CNT_MAX) ? CNT_MAX : bit_cnt + CNT_W'(1);
   assign cnt_ok   = (cnt_incl == CNT_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_left = 1'b0;
      pair_done = 1'b0;
      slot_err  = 1'b0;
      if (!en) begin
         state_nxt = ST_SYNC;
      end else if (boundary) begin
         case (state)
            ST_SYNC: begin
               if (!lr_q) begin
                  state_nxt = ST_LEFT;
               end
            end
            ST_LEFT: begin
               if (lr_q && cnt_ok) begin
                  state_nxt = ST_RIGHT;
                  load_left = 1'b1;
               end else begin
                  state_nxt = ST_SYNC;
                  slot_err  = 1'b1;
               end
            end
            ST_RIGHT: begin
               if (!lr_q && cnt_ok) begin
                  state_nxt = ST_LEFT;
                  pair_done = 1'b1;
               end else begin
                  state_nxt = ST_SYNC;
                  slot_err  = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_SYNC;
            end
         endcase
      end
   end

   // Shifting and slot tracking run whenever a bclk rise is seen,
   // independent of en. This keeps lr_prev true to the stream, so
   // relocking after en returns only waits for the next left-start boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg        <= '0;
         bit_cnt      <= '0;
         lr_prev      <= 1'b0;
         left_hold    <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= pair_done;
         frame_err    <= slot_err;
         if (rise_q) begin
            shreg   <= word_nxt[DATA_W-2:0];
            lr_prev <= lr_q;
            bit_cnt <= boundary ? '0 : cnt_incl;
         end
         if (load_left) begin
            left_hold <= word_nxt;
         end
         if (pair_done) begin
            left_data  <= left_hold;
            right_data <= word_nxt;
         end
      end
   end

endmodule
